logic_seq_unit: RTL and testbench

Handshaked, sequential companion to the combinational logic unit.
- Accepts one operation request (op, a, b) over a valid/ready input channel.
- Executes AND/OR/XOR in one step, and shifts iteratively one bit per cycle.
- Returns the result with flags over a valid/ready output channel.
- Sits between the operand/command source (switch/FSM front-end) and the result consumer (display/register file). One operation is in flight at a time.

---
 rtl/logic_seq_pkg.sv | 25 ++
 rtl/logic_shift_step.sv | 14 +
 rtl/logic_seq_unit.sv | 137 +++++++++++++
 tb/tb_logic_seq_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_seq_pkg.sv
// Shared types and helpers for the sequential logic unit and its shift step.
// Optional feature macro: LOGIC_SEQ_ASR_EN (enables op 5 as arithmetic shift right).
package logic_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_SHR = 3'd3,
        OP_SHL = 3'd4,
        OP_ASR = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/logic_shift_step.sv
// Combinational single-bit shifter: one iteration of the SHIFT datapath.
module logic_shift_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] value_i,
    input  logic         dir_left_i,
    input  logic         fill_i,
    output logic [N-1:0] next_o
);

    assign next_o = dir_left_i ? {value_i[N-2:0], fill_i}
                               : {fill_i, value_i[N-1:1]};

endmodule

// File: rtl/logic_seq_unit.sv
// Handshaked logic unit: AND/OR/XOR in one step, shifts one bit per cycle.
// Optional feature macro: LOGIC_SEQ_ASR_EN (op 5 = arithmetic shift right).
module logic_seq_unit
    import logic_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         err
);

    localparam int CNT_W = cnt_w(N);

    state_t           state_q, state_d;
    logic [N-1:0]     work_q, work_d;
    logic [N-1:0]     result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_init;
    logic [N-1:0]     step_out;
    logic             shift_left;
    logic             fill_bit;

    // Shift amounts at or beyond N all clamp to N iterations.
    assign cnt_init   = (b >= N'(N)) ? CNT_W'(N) : CNT_W'(b);
    assign shift_left = (op_q == OP_SHL);

`ifdef LOGIC_SEQ_ASR_EN
    assign fill_bit = (op_q == OP_ASR) ? work_q[N-1] : 1'b0;
`else
    assign fill_bit = 1'b0;
`endif

    logic_shift_step #(.N(N)) u_step (
        .value_i    (work_q),
        .dir_left_i (shift_left),
        .fill_i     (fill_bit),
        .next_o     (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        zero_d    = zero_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d     = op;
                    work_d   = a;
                    cnt_d    = cnt_init;
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                    case (op)
                        OP_AND: result_d = a & b;
                        OP_OR:  result_d = a | b;
                        OP_XOR: result_d = a ^ b;
                        OP_SHR, OP_SHL: begin
                            if (cnt_init == '0) result_d = a;
                            else                state_d  = SHIFT;
                        end
`ifdef LOGIC_SEQ_ASR_EN
                        OP_ASR: begin
                            if (cnt_init == '0) result_d = a;
                            else                state_d  = SHIFT;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - CNT_W'(1);
                // Last iteration: the shifted value is the final result.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = step_out;
                    zero_d   = (step_out == '0);
                    err_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_logic_seq_unit.sv
// Directed self-checking bench for logic_seq_unit (N=4).
module tb_logic_seq_unit;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         err;

    int n_pass  = 0;
    int n_total = 0;

    logic_seq_unit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  8'(in_ready),  8'h1);
        chk("rst_out_valid", 8'(out_valid), 8'h0);
        chk("rst_result",    8'(result),    8'h0);
        chk("rst_zero",      8'(zero),      8'h0);
        chk("rst_err",       8'(err),       8'h0);
        rst_n = 1'b1;
        tick();

        // AND, single-cycle latency
        out_ready = 1'b1;
        op = 3'd0; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("and_valid",  8'(out_valid), 8'h1);
        chk("and_result", 8'(result),    8'h8);
        chk("and_zero",   8'(zero),      8'h0);
        chk("and_err",    8'(err),       8'h0);
        chk("and_busy",   8'(in_ready),  8'h0);
        tick();
        chk("and_ready_after", 8'(in_ready),  8'h1);
        chk("and_valid_after", 8'(out_valid), 8'h0);

        // SHL by 2: DONE two edges after the accept edge
        op = 3'd4; a = 4'b0011; b = 4'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("shl_ready_s1", 8'(in_ready),  8'h0);
        chk("shl_valid_s1", 8'(out_valid), 8'h0);
        tick();
        chk("shl_ready_s2", 8'(in_ready),  8'h0);
        chk("shl_valid_s2", 8'(out_valid), 8'h0);
        tick();
        chk("shl_valid",  8'(out_valid), 8'h1);
        chk("shl_result", 8'(result),    8'hC);
        chk("shl_zero",   8'(zero),      8'h0);
        chk("shl_err",    8'(err),       8'h0);
        tick();

        // SHR with b=7 clamps to 4 iterations
        op = 3'd3; a = 4'b1011; b = 4'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("shr_wait_valid", 8'(out_valid), 8'h0);
            tick();
        end
        chk("shr_wait_last", 8'(out_valid), 8'h0);
        tick();
        chk("shr_valid",  8'(out_valid), 8'h1);
        chk("shr_result", 8'(result),    8'h0);
        chk("shr_zero",   8'(zero),      8'h1);
        chk("shr_err",    8'(err),       8'h0);
        tick();

`ifdef LOGIC_SEQ_ASR_EN
        op = 3'd5; a = 4'b1011; b = 4'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("asr_wait_valid", 8'(out_valid), 8'h0);
            tick();
        end
        chk("asr_valid",  8'(out_valid), 8'h1);
        chk("asr_result", 8'(result),    8'hF);
        chk("asr_zero",   8'(zero),      8'h0);
        chk("asr_err",    8'(err),       8'h0);
        tick();
`endif

        // XOR under backpressure, with a stray request during the stall
        out_ready = 1'b0;
        op = 3'd2; a = 4'b0110; b = 4'b0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("xor_valid",  8'(out_valid), 8'h1);
        chk("xor_result", 8'(result),    8'h3);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                op = 3'd0; a = 4'hF; b = 4'hF; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("xor_stall_valid",  8'(out_valid), 8'h1);
            chk("xor_stall_result", 8'(result),    8'h3);
            chk("xor_stall_ready",  8'(in_ready),  8'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("xor_release_valid", 8'(out_valid), 8'h0);
        chk("xor_release_ready", 8'(in_ready),  8'h1);
        tick();
        chk("xor_no_stray", 8'(out_valid), 8'h0);

        // Illegal op 6
        op = 3'd6; a = 4'b1111; b = 4'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill6_valid",  8'(out_valid), 8'h1);
        chk("ill6_result", 8'(result),    8'h0);
        chk("ill6_zero",   8'(zero),      8'h1);
        chk("ill6_err",    8'(err),       8'h1);
        tick();

`ifndef LOGIC_SEQ_ASR_EN
        op = 3'd5; a = 4'b1011; b = 4'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill5_valid",  8'(out_valid), 8'h1);
        chk("ill5_result", 8'(result),    8'h0);
        chk("ill5_zero",   8'(zero),      8'h1);
        chk("ill5_err",    8'(err),       8'h1);
        tick();
`endif

        // Logic op after an illegal one clears err
        op = 3'd1; a = 4'b0001; b = 4'b0100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("or_result", 8'(result), 8'h5);
        chk("or_err",    8'(err),    8'h0);
        tick();

        // Asynchronous reset in the second SHIFT cycle
        op = 3'd4; a = 4'b0001; b = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("abort_busy", 8'(in_ready), 8'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid",  8'(out_valid), 8'h0);
        chk("abort_result", 8'(result),    8'h0);
        chk("abort_ready",  8'(in_ready),  8'h1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_valid", 8'(out_valid), 8'h0);
            chk("post_abort_ready", 8'(in_ready),  8'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
